button_bank: RTL and testbench
==============================

# button_bank

Parametrised multi-channel push-button conditioner for the board's user inputs. Single clock domain with a shared tick-enable instead of a divided clock. Per channel: synchronizes the raw button, debounces it on the tick, and reports press/release edges as one-`clk` pulses. Adds long-press detection and optional auto-repeat while held.

## Interface
- `CHANNELS`, 4: number of independent button channels (≥1).
- `CLK_DIV`, 250000: `clk` cycles per sample tick (≥2); 200 Hz at 50 MHz.
- `DEBOUNCE_TICKS`, 4: consecutive disagreeing ticks required to change the debounced level (≥1).
- `HOLD_TICKS`, 200: ticks after press before a long-press is declared (≥1).
- `REPEAT_TICKS`, 40: ticks between auto-repeat pulses while held (≥1).
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  one clock; reset is synchronous and active-low.
- `btn_in`  in  CHANNELS  raw asynchronous button inputs, 1 = pressed.
- `repeat_en`  in  CHANNELS  per-channel auto-repeat enable, sampled on `clk`.
- `btn_level`  out  CHANNELS  debounced level.
- `btn_press`  out  CHANNELS  one-cycle pulse on debounced 0→1.
- `btn_release`  out  CHANNELS  one-cycle pulse on debounced 1→0.
- `btn_held`  out  CHANNELS  level, high while channel is in HELD.
- `btn_hold`  out  CHANNELS  one-cycle pulse on entry to HELD.
- `btn_repeat`  out  CHANNELS  one-cycle auto-repeat pulse.

## Operation
- Reset (`rst`=0 at an edge): all outputs 0; synchronizer flops, divider, and all per-channel counters 0; every channel IDLE. The debounced level resets to 0 (released).
- Synchronizer: 2 flops per channel on every `clk`. `sync[i]` is `btn_in[i]` delayed by 2 cycles.
- Tick: shared counter 0..CLK_DIV-1. `tick`=1 for the one cycle the counter equals CLK_DIV-1; the counter then wraps to 0.
- Debounce, evaluated only on tick cycles:
  - If `sync[i]` ≠ `btn_level[i]`, increment `db_cnt[i]`.
  - If `sync[i]` = `btn_level[i]`, clear `db_cnt[i]`.
  - When the increment would reach DEBOUNCE_TICKS, toggle `btn_level[i]` and clear `db_cnt[i]`.
  - `btn_press` or `btn_release` is registered on the same edge the level toggles and is high for exactly one `clk` cycle.
- Per-channel FSM with states IDLE, PRESSED, HELD:
  - IDLE → PRESSED on level rise; `hold_cnt` ← 0.
  - PRESSED: each tick increments `hold_cnt`. On the tick where it would reach HOLD_TICKS, go to HELD, pulse `btn_hold`, set `btn_held`, and set `rpt_cnt` ← 0.
  - HELD with `repeat_en[i]`=1: each tick increments `rpt_cnt`. On reaching REPEAT_TICKS, pulse `btn_repeat` and clear `rpt_cnt`.
  - HELD with `repeat_en[i]`=0: `rpt_cnt` is held at 0 and no repeat pulses are produced. Re-enabling restarts counting from 0.
  - PRESSED or HELD → IDLE on level fall. `btn_held` clears on that same edge; counters clear.
- Simultaneous events:
  - The press-edge tick is not counted toward `hold_cnt`.
  - If level fall and hold threshold occur on the same tick, release wins: IDLE, no `btn_hold`.
  - If level fall and repeat threshold occur on the same tick, there is no `btn_repeat`.
- Counter widths: `$clog2` of their terminal value plus 1. Counters never wrap beyond their threshold.

## Timing
- Pulse outputs are high for exactly 1 `clk` cycle and only on tick cycles. No output is combinational from `btn_in`.
- Press latency after `btn_in` becomes stable: 2 cycles of synchronization, then DEBOUNCE_TICKS ticks. Worst case is 2 + DEBOUNCE_TICKS·CLK_DIV cycles.
- A glitch shorter than DEBOUNCE_TICKS consecutive ticks produces no output.
- `btn_hold` arrives HOLD_TICKS ticks after `btn_press`. Successive `btn_repeat` pulses are REPEAT_TICKS ticks apart; the first comes REPEAT_TICKS ticks after `btn_hold`.
- Reset asserted mid-press: everything clears. If the button is still down after reset, a fresh `btn_press` follows after the normal debounce.
- Channels are fully independent and may pulse in the same cycle.

## Test plan
Bench parameters: CHANNELS=2, CLK_DIV=4, DEBOUNCE_TICKS=3, HOLD_TICKS=5, REPEAT_TICKS=2.
- Reset: hold `rst`=0 for 3 cycles with `btn_in`=2'b11 → all outputs 0 during reset. First `btn_press` comes no earlier than 3 ticks after release of reset.
- Clean press/release on ch0 → `btn_press[0]` pulses once, 1 cycle wide, ≤2+12 cycles after the input edge. `btn_level[0]`=1. On release, `btn_release[0]` pulses once and the level returns to 0.
- Bounce: toggle ch0 high for 2 ticks, low for 1 tick, then high steadily → exactly one `btn_press`, occurring 3 ticks after the final rise.
- Long press with `repeat_en`=1, held 15 ticks after press → `btn_hold` at tick 5 and `btn_repeat` at ticks 7, 9, 11, 13, 15. `btn_held`=1 from tick 5 until release.
- `repeat_en`=0 while held, then set back to 1 → no repeats while 0; first repeat 2 ticks after re-enable. Separately, a release landing on tick 5 produces no `btn_hold`.
- Both channels pressed in the same cycle → identical simultaneous pulses on both. Reset mid-HELD → `btn_held`=0 on the next edge.

Source files
------------

// File: rtl/button_bank_if.sv
// Signal bundle between the button conditioner and its user: raw inputs and
// repeat enables in, debounced levels and event pulses out.
interface button_bank_if #(
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0] btn_in;
    logic [CHANNELS-1:0] repeat_en;
    logic [CHANNELS-1:0] btn_level;
    logic [CHANNELS-1:0] btn_press;
    logic [CHANNELS-1:0] btn_release;
    logic [CHANNELS-1:0] btn_held;
    logic [CHANNELS-1:0] btn_hold;
    logic [CHANNELS-1:0] btn_repeat;

    modport master (
        output btn_in, repeat_en,
        input  btn_level, btn_press, btn_release, btn_held, btn_hold, btn_repeat
    );

    modport slave (
        input  btn_in, repeat_en,
        output btn_level, btn_press, btn_release, btn_held, btn_hold, btn_repeat
    );
endinterface

// File: rtl/button_bank.sv
// Multi-channel push-button conditioner: 2-flop sync, tick-based debounce,
// press/release edge pulses, long-press detection and auto-repeat.
module button_bank #(
    parameter int CHANNELS       = 4,
    parameter int CLK_DIV        = 250000,
    parameter int DEBOUNCE_TICKS = 4,
    parameter int HOLD_TICKS     = 200,
    parameter int REPEAT_TICKS   = 40
) (
    input  logic         clk,
    input  logic         rst,
    button_bank_if.slave bus
);
    localparam int DIV_W  = $clog2(CLK_DIV) + 1;
    localparam int DB_W   = $clog2(DEBOUNCE_TICKS) + 1;
    localparam int HOLD_W = $clog2(HOLD_TICKS) + 1;
    localparam int RPT_W  = $clog2(REPEAT_TICKS) + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } state_e;

    logic [CHANNELS-1:0]             sync1_q, sync2_q;
    logic [DIV_W-1:0]                div_q, div_d;
    logic                            tick;

    state_e                          state_q [CHANNELS];
    state_e                          state_d [CHANNELS];
    logic [CHANNELS-1:0][DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic [CHANNELS-1:0][HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [CHANNELS-1:0][RPT_W-1:0]  rpt_cnt_q, rpt_cnt_d;

    logic [CHANNELS-1:0]             level_q, level_d;
    logic [CHANNELS-1:0]             press_q, press_d;
    logic [CHANNELS-1:0]             release_q, release_d;
    logic [CHANNELS-1:0]             hold_q, hold_d;
    logic [CHANNELS-1:0]             repeat_q, repeat_d;
    logic [CHANNELS-1:0]             rise_c, fall_c;
    logic [CHANNELS-1:0]             held_c;

    assign tick  = (div_q == DIV_W'(CLK_DIV - 1));
    assign div_d = tick ? '0 : div_q + 1'b1;

    always_comb begin
        rise_c     = '0;
        fall_c     = '0;
        level_d    = level_q;
        db_cnt_d   = db_cnt_q;
        hold_cnt_d = hold_cnt_q;
        rpt_cnt_d  = rpt_cnt_q;
        hold_d     = '0;
        repeat_d   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i] = state_q[i];

            if (tick) begin
                if (sync2_q[i] != level_q[i]) begin
                    if (db_cnt_q[i] == DB_W'(DEBOUNCE_TICKS - 1)) begin
                        level_d[i]  = ~level_q[i];
                        db_cnt_d[i] = '0;
                        rise_c[i]   = sync2_q[i];
                        fall_c[i]   = ~sync2_q[i];
                    end else begin
                        db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                    end
                end else begin
                    db_cnt_d[i] = '0;
                end
            end

            // A debounced fall always takes priority over hold/repeat thresholds.
            case (state_q[i])
                IDLE: begin
                    hold_cnt_d[i] = '0;
                    rpt_cnt_d[i]  = '0;
                    if (rise_c[i]) begin
                        state_d[i] = PRESSED;
                    end
                end
                PRESSED: begin
                    if (fall_c[i]) begin
                        state_d[i]    = IDLE;
                        hold_cnt_d[i] = '0;
                        rpt_cnt_d[i]  = '0;
                    end else if (tick) begin
                        if (hold_cnt_q[i] == HOLD_W'(HOLD_TICKS - 1)) begin
                            state_d[i]    = HELD;
                            hold_d[i]     = 1'b1;
                            hold_cnt_d[i] = '0;
                            rpt_cnt_d[i]  = '0;
                        end else begin
                            hold_cnt_d[i] = hold_cnt_q[i] + 1'b1;
                        end
                    end
                end
                HELD: begin
                    if (fall_c[i]) begin
                        state_d[i]    = IDLE;
                        hold_cnt_d[i] = '0;
                        rpt_cnt_d[i]  = '0;
                    end else if (!bus.repeat_en[i]) begin
                        rpt_cnt_d[i] = '0;
                    end else if (tick) begin
                        if (rpt_cnt_q[i] == RPT_W'(REPEAT_TICKS - 1)) begin
                            repeat_d[i]  = 1'b1;
                            rpt_cnt_d[i] = '0;
                        end else begin
                            rpt_cnt_d[i] = rpt_cnt_q[i] + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d[i]    = IDLE;
                    hold_cnt_d[i] = '0;
                    rpt_cnt_d[i]  = '0;
                end
            endcase
        end
        press_d   = rise_c;
        release_d = fall_c;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            div_q      <= '0;
            db_cnt_q   <= '0;
            hold_cnt_q <= '0;
            rpt_cnt_q  <= '0;
            level_q    <= '0;
            press_q    <= '0;
            release_q  <= '0;
            hold_q     <= '0;
            repeat_q   <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= IDLE;
            end
        end else begin
            sync1_q    <= bus.btn_in;
            sync2_q    <= sync1_q;
            div_q      <= div_d;
            db_cnt_q   <= db_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            rpt_cnt_q  <= rpt_cnt_d;
            level_q    <= level_d;
            press_q    <= press_d;
            release_q  <= release_d;
            hold_q     <= hold_d;
            repeat_q   <= repeat_d;
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= state_d[i];
            end
        end
    end

    always_comb begin
        held_c = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            held_c[i] = (state_q[i] == HELD);
        end
    end

    assign bus.btn_level   = level_q;
    assign bus.btn_press   = press_q;
    assign bus.btn_release = release_q;
    assign bus.btn_held    = held_c;
    assign bus.btn_hold    = hold_q;
    assign bus.btn_repeat  = repeat_q;
endmodule

// File: tb/tb_button_bank.sv
// Directed bench for button_bank: per-edge expectations for two channels with a
// 4-cycle tick, plus pulse-count totals per scenario.
module tb_button_bank;
    localparam int CH = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    button_bank_if #(.CHANNELS(CH)) bb_if ();

    button_bank #(
        .CHANNELS      (CH),
        .CLK_DIV       (4),
        .DEBOUNCE_TICKS(3),
        .HOLD_TICKS    (5),
        .REPEAT_TICKS  (2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bb_if)
    );

    // Edge index since the last reset edge; ticks land on multiples of 4.
    int ecnt = 0;
    int n_press = 0, n_rel = 0, n_hold = 0, n_rpt = 0;

    always @(posedge clk) ecnt <= rst ? ecnt + 1 : 0;

    always @(negedge clk) begin
        if (rst) begin
            n_press <= n_press + $countones(bb_if.btn_press);
            n_rel   <= n_rel + $countones(bb_if.btn_release);
            n_hold  <= n_hold + $countones(bb_if.btn_hold);
            n_rpt   <= n_rpt + $countones(bb_if.btn_repeat);
        end
    end

    typedef enum int {K_CHK, K_RST, K_CNT} kind_e;

    typedef struct {
        kind_e      kind;
        int         e;
        logic [1:0] bin, ren;
        logic [1:0] lvl, prs, rel, hld, hold, rpt;
        int         c_prs, c_rel, c_hold, c_rpt;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int errors = 0;

    function automatic void add_chk(input int e, input logic [1:0] bin, input logic [1:0] ren,
                                    input logic [1:0] lvl, input logic [1:0] prs,
                                    input logic [1:0] rel, input logic [1:0] hld,
                                    input logic [1:0] hold, input logic [1:0] rpt);
        vec_t v;
        v = '{kind: K_CHK, e: e, bin: bin, ren: ren, lvl: lvl, prs: prs, rel: rel, hld: hld,
              hold: hold, rpt: rpt, c_prs: 0, c_rel: 0, c_hold: 0, c_rpt: 0};
        vecs.push_back(v);
    endfunction

    function automatic void add_rst(input int e, input logic [1:0] bin, input logic [1:0] ren);
        vec_t v;
        v = '{kind: K_RST, e: e, bin: bin, ren: ren, lvl: 2'b00, prs: 2'b00, rel: 2'b00,
              hld: 2'b00, hold: 2'b00, rpt: 2'b00, c_prs: 0, c_rel: 0, c_hold: 0, c_rpt: 0};
        vecs.push_back(v);
    endfunction

    function automatic void add_cnt(input int p, input int r, input int h, input int rp);
        vec_t v;
        v = '{kind: K_CNT, e: 0, bin: 2'b00, ren: 2'b00, lvl: 2'b00, prs: 2'b00, rel: 2'b00,
              hld: 2'b00, hold: 2'b00, rpt: 2'b00, c_prs: p, c_rel: r, c_hold: h, c_rpt: rp};
        vecs.push_back(v);
    endfunction

    task automatic cmp(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @edge %0d: got %0d, expected %0d", nm, ecnt, act, exp);
        end
    endtask

    task automatic cmp_outs(input string tag, input vec_t v);
        cmp({tag, ".level"},   int'(bb_if.btn_level),   int'(v.lvl));
        cmp({tag, ".press"},   int'(bb_if.btn_press),   int'(v.prs));
        cmp({tag, ".release"}, int'(bb_if.btn_release), int'(v.rel));
        cmp({tag, ".held"},    int'(bb_if.btn_held),    int'(v.hld));
        cmp({tag, ".hold"},    int'(bb_if.btn_hold),    int'(v.hold));
        cmp({tag, ".repeat"},  int'(bb_if.btn_repeat),  int'(v.rpt));
    endtask

    task automatic goto_edge(input int e);
        int guard = 0;
        while (ecnt < e && guard < 1000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (ecnt != e) begin
            errors++;
            $display("FAIL edge_sync: at edge %0d, wanted edge %0d", ecnt, e);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sp, sr, sh, srp;
        vec_t v;
        sp = 0; sr = 0; sh = 0; srp = 0;
        bb_if.btn_in    = 2'b00;
        bb_if.repeat_en = 2'b00;

        // Both channels held through reset; simultaneous press, hold, then reset mid-HELD.
        add_rst(0, 2'b11, 2'b00);
        add_chk(11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        add_chk(12, 2'b11, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
        add_chk(13, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        add_chk(31, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        add_chk(32, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11, 2'b11, 2'b00);
        add_chk(33, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00);
        add_cnt(2, 0, 2, 0);
        add_rst(33, 2'b11, 2'b00);
        add_chk(11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        add_chk(12, 2'b11, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
        add_chk(13, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        add_cnt(2, 0, 0, 0);

        // Long press on ch0 with repeat enabled; released after the repeat at tick 13.
        add_rst(13, 2'b00, 2'b01);
        add_chk(1,  2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        add_chk(11, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        add_chk(12, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
        add_chk(13, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        add_chk(31, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        add_chk(32, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00);
        add_chk(33, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        add_chk(39, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        add_chk(40, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01);
        add_chk(41, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        add_chk(48, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01);
        add_chk(64, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01);
        add_chk(72, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01);
        add_chk(75, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        add_chk(76, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
        add_chk(77, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        add_cnt(1, 1, 1, 5);

        // Repeat disabled while held, re-enabled; release lands on a repeat tick.
        add_rst(77, 2'b00, 2'b00);
        add_chk(1,  2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        add_chk(12, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
        add_chk(32, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00);
        add_chk(45, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        add_chk(48, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        add_chk(52, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01);
        add_chk(56, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        add_chk(60, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01);
        add_chk(64, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        add_chk(68, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01);
        add_chk(76, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
        add_chk(77, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        add_cnt(1, 1, 1, 3);

        // Bounce (2 ticks high, 1 low) then steady; release lands on the hold tick.
        add_rst(77, 2'b00, 2'b00);
        add_chk(1,  2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        add_chk(8,  2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        add_chk(12, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        add_chk(23, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        add_chk(24, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
        add_chk(32, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        add_chk(43, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        add_chk(44, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
        add_chk(45, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        add_cnt(1, 1, 0, 0);

        for (int k = 0; k < vecs.size(); k++) begin
            v = vecs[k];
            case (v.kind)
                K_CHK: begin
                    goto_edge(v.e);
                    cmp_outs($sformatf("v%0d", k), v);
                    bb_if.btn_in    = v.bin;
                    bb_if.repeat_en = v.ren;
                end
                K_RST: begin
                    if (v.e > 0) goto_edge(v.e);
                    bb_if.btn_in    = v.bin;
                    bb_if.repeat_en = v.ren;
                    rst = 1'b0;
                    for (int r = 0; r < 3; r++) begin
                        @(posedge clk);
                        #1;
                        cmp_outs($sformatf("rst%0d_%0d", k, r), v);
                    end
                    rst = 1'b1;
                end
                default: begin
                    cmp($sformatf("cnt%0d.press", k),   n_press - sp, v.c_prs);
                    cmp($sformatf("cnt%0d.release", k), n_rel - sr,   v.c_rel);
                    cmp($sformatf("cnt%0d.hold", k),    n_hold - sh,  v.c_hold);
                    cmp($sformatf("cnt%0d.repeat", k),  n_rpt - srp,  v.c_rpt);
                    sp = n_press; sr = n_rel; sh = n_hold; srp = n_rpt;
                end
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
